// File: rtl/bitplane_shift_accumulator.sv
// bitplane_shift_accumulator: issues activation bit-planes and shift-adds returned popcounts into a signed dot product
module bitplane_shift_accumulator #(
    parameter int IN_BITS  = 8,
    parameter int SUM_W    = 8,
    parameter int TREE_LAT = 3,
    parameter int ACC_W    = SUM_W + IN_BITS + 1,
    parameter int IDX_W    = $clog2(IN_BITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    output logic             ready,
    output logic             plane_en,
    output logic [IDX_W-1:0] plane_sel,
    input  logic [SUM_W-1:0] sum_in,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_data
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(IN_BITS - 1);
    localparam int               L    = TREE_LAT - 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t              state;
    logic [IDX_W-1:0]    cnt;
    logic                sgn_job;
    logic                cur_sgn;
    logic [TREE_LAT-1:0] tv;
    logic [TREE_LAT-1:0] ts;
    logic [TREE_LAT-1:0] tl;
    logic [IDX_W-1:0]    ti [TREE_LAT];
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    mag;
    logic [ACC_W-1:0]    term;
    logic [ACC_W-1:0]    nxt;

    assign ready     = (state == IDLE);
    assign plane_en  = (state == ISSUE) || start;
    assign plane_sel = (state == ISSUE) ? cnt : '0;
    assign cur_sgn   = (state == IDLE) ? signed_mode : sgn_job;

    // Issue FSM: plane 0 goes out with the accepted start, planes 1..IN_BITS-1 follow
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sgn_job <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                state   <= ISSUE;
                cnt     <= IDX_W'(1);
                sgn_job <= signed_mode;
            end
        end else if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            cnt <= cnt + IDX_W'(1);
        end
    end

    // Tag pipeline: each plane's attributes travel alongside its popcount through the tree
    always_ff @(posedge clk) begin
        if (rst) begin
            tv <= '0;
        end else begin
            tv[0] <= plane_en;
            ts[0] <= cur_sgn;
            tl[0] <= (plane_sel == LAST);
            ti[0] <= plane_sel;
            for (int i = 1; i < TREE_LAT; i++) begin
                tv[i] <= tv[i-1];
                ts[i] <= ts[i-1];
                tl[i] <= tl[i-1];
                ti[i] <= ti[i-1];
            end
        end
    end

    assign mag  = ACC_W'(sum_in) << ti[L];
    assign term = (ts[L] && ti[L] == LAST) ? -mag : mag;
    assign nxt  = ((ti[L] == '0) ? '0 : acc) + term;

    // Shift-add accumulation; plane 0 restarts the sum, last plane publishes it
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            if (tv[L]) begin
                acc <= nxt;
                if (tl[L]) begin
                    out_data  <= nxt;
                    out_valid <= 1'b1;
                end
            end
        end
    end
endmodule
